// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache backing-memory responder.
//   state_e          : responder FSM states
//   WORD_OFFSET_BITS : byte-offset bits inside one 32-bit word
//   clog2            : ceiling log2, used for array index / block offset widths
//   sat_inc16        : 16-bit saturating increment for the burst counters
package cache_mem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    RD_BEAT = 3'd2,
    WR_BEAT = 3'd3,
    WR_ACK  = 3'd4
  } state_e;

  localparam int WORD_OFFSET_BITS = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/cache_mem_array.sv
// Word array behind the responder: single address port, synchronous write,
// asynchronous read. Contents are deliberately not reset.
//   clk     : write clock
//   we_i    : write enable
//   addr_i  : word index shared by read and write
//   wdata_i : write word
//   rdata_o : word currently addressed
module cache_mem_array #(
  parameter int MEM_WORDS  = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // Store one word on a write strobe.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/cache_mem_responder.sv
// Main-memory responder for the L1 cache: accepts block reads and writes,
// waits LATENCY cycles, then streams (read) or absorbs (write) BLOCK_WORDS
// beats, acknowledging a write with a single rsp_last beat of zero data.
//   clk, reset                  : clock, asynchronous active-low reset
//   req_valid/ready/write/addr  : block request channel
//   wdata_valid/ready, wdata    : write beat channel
//   rsp_valid/ready/data/last   : read beat / write acknowledge channel
//   busy                        : responder not in IDLE
//   rd_count, wr_count          : saturating completed-burst counters
// All outputs are registered; they are computed from next-state values.
module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  busy,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  localparam int MW_BITS   = clog2(MEM_WORDS);
  localparam int BOFF_BITS = clog2(BLOCK_WORDS);
  localparam int BEAT_W    = 5;
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BLOCK_WORDS - 1);
  localparam logic [MW_BITS-1:0] BLOCK_MASK = {MW_BITS{1'b1}} << BOFF_BITS;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [MW_BITS-1:0]   base_q, base_d;
  logic                 write_q, write_d;
  logic [15:0]          rd_count_q, rd_count_d;
  logic [15:0]          wr_count_q, wr_count_d;
  logic                 req_ready_q, req_ready_d;
  logic                 wdata_ready_q, wdata_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_last_q, rsp_last_d;
  logic                 busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic                  mem_we_s;
  logic [MW_BITS-1:0]    mem_addr_s;
  logic [DATA_WIDTH-1:0] mem_rdata_s;
  logic                  unused_addr_s;

  // Only the word-index bits of the address matter; the rest wraps away.
  assign unused_addr_s = ^req_addr;

  cache_mem_array #(
    .MEM_WORDS (MEM_WORDS),
    .DATA_WIDTH(DATA_WIDTH),
    .AW        (MW_BITS)
  ) u_array (
    .clk    (clk),
    .we_i   (mem_we_s),
    .addr_i (mem_addr_s),
    .wdata_i(wdata),
    .rdata_o(mem_rdata_s)
  );

  // Next-state, counter and datapath decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    base_d     = base_q;
    write_d    = write_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    mem_we_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d = req_write;
          base_d  = req_addr[WORD_OFFSET_BITS +: MW_BITS] & BLOCK_MASK;
          beat_d  = {BEAT_W{1'b0}};
          cnt_d   = 8'(LATENCY);
          if (LATENCY == 0) begin
            state_d = req_write ? WR_BEAT : RD_BEAT;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = write_q ? WR_BEAT : RD_BEAT;
        end else begin
          state_d = WAIT;
        end
      end
      RD_BEAT: begin
        if (rsp_ready) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d    = IDLE;
            rd_count_d = sat_inc16(rd_count_q);
          end else begin
            state_d = RD_BEAT;
          end
        end else begin
          state_d = RD_BEAT;
        end
      end
      WR_BEAT: begin
        if (wdata_valid) begin
          mem_we_s = 1'b1;
          beat_d   = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = WR_ACK;
          end else begin
            state_d = WR_BEAT;
          end
        end else begin
          state_d = WR_BEAT;
        end
      end
      WR_ACK: begin
        if (rsp_ready) begin
          state_d    = IDLE;
          wr_count_d = sat_inc16(wr_count_q);
        end else begin
          state_d = WR_ACK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Writes use the current beat; otherwise the array is pointed at the
    // beat that will be presented next, so rsp_data can be registered.
    if (state_q == WR_BEAT) begin
      mem_addr_s = base_q + MW_BITS'(beat_q);
    end else begin
      mem_addr_s = base_d + MW_BITS'(beat_d);
    end

    req_ready_d   = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    wdata_ready_d = (state_d == WR_BEAT);
    rsp_valid_d   = (state_d == RD_BEAT) || (state_d == WR_ACK);
    rsp_last_d    = ((state_d == RD_BEAT) && (beat_d == LAST_BEAT)) || (state_d == WR_ACK);
    if (state_d == RD_BEAT) begin
      rsp_data_d = mem_rdata_s;
    end else begin
      rsp_data_d = {DATA_WIDTH{1'b0}};
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      beat_q        <= {BEAT_W{1'b0}};
      base_q        <= {MW_BITS{1'b0}};
      write_q       <= 1'b0;
      rd_count_q    <= 16'd0;
      wr_count_q    <= 16'd0;
      req_ready_q   <= 1'b1;
      wdata_ready_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      rsp_data_q    <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      beat_q        <= beat_d;
      base_q        <= base_d;
      write_q       <= write_d;
      rd_count_q    <= rd_count_d;
      wr_count_q    <= wr_count_d;
      req_ready_q   <= req_ready_d;
      wdata_ready_q <= wdata_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_last_q    <= rsp_last_d;
      busy_q        <= busy_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign wdata_ready = wdata_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_last    = rsp_last_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = busy_q;
  assign rd_count    = rd_count_q;
  assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: one instance with LATENCY=4 and one with
// LATENCY=0, driven with directed and random bursts and compared against a
// word-array reference model with expected burst counts.
module tb_cache_mem_responder;

  localparam int MW = 1024;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic reset;

  logic        req_valid   [2];
  logic        req_write   [2];
  logic [31:0] req_addr    [2];
  logic        wdata_valid [2];
  logic [31:0] wdata       [2];
  logic        rsp_ready   [2];
  logic        req_ready   [2];
  logic        wdata_ready [2];
  logic        rsp_valid   [2];
  logic [31:0] rsp_data    [2];
  logic        rsp_last    [2];
  logic        busy        [2];
  logic [15:0] rd_count    [2];
  logic [15:0] wr_count    [2];

  logic [31:0] ref_mem [2][MW];
  bit          known   [2][MW];
  int          exp_rd  [2];
  int          exp_wr  [2];
  int          lat_of  [2];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  cache_mem_responder #(.LATENCY(4)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]), .req_addr(req_addr[0]),
    .wdata_valid(wdata_valid[0]), .wdata_ready(wdata_ready[0]), .wdata(wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_last(rsp_last[0]),
    .busy(busy[0]), .rd_count(rd_count[0]), .wr_count(wr_count[0])
  );

  cache_mem_responder #(.LATENCY(0)) u_dut_lat0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]), .req_addr(req_addr[1]),
    .wdata_valid(wdata_valid[1]), .wdata_ready(wdata_ready[1]), .wdata(wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_last(rsp_last[1]),
    .busy(busy[1]), .rd_count(rd_count[1]), .wr_count(wr_count[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Word index of beat 0: word address wrapped to the array, block aligned.
  function automatic int blk_base(input logic [31:0] a);
    int unsigned w;
    w = (a / 4) % MW;
    return int'((w / BW) * BW);
  endfunction

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Present a request at a negedge and count the cycles until the first beat.
  task automatic start_req(input int d, input bit wr, input logic [31:0] a);
    int n;
    chk("req_ready_idle", req_ready[d], 1);
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = a;
    @(negedge clk);
    req_valid[d] = 1'b0; req_addr[d] = $urandom;
    chk("busy_after_accept", busy[d], 1);
    chk("req_ready_busy", req_ready[d], 0);
    n = 0;
    while (!(wr ? wdata_ready[d] : rsp_valid[d]) && n < 300) begin
      wdata_valid[d] = 1'($urandom_range(0, 1));
      wdata[d] = $urandom;
      @(negedge clk);
      n++;
    end
    wdata_valid[d] = 1'b0;
    chk("first_beat_latency", n, lat_of[d]);
  endtask

  task automatic wr_burst(input int d, input logic [31:0] a, input bit use_pat,
                          input logic [6:0] pat, input bit fixed, input logic [31:0] d0);
    int base, k, p, n;
    bit v;
    logic [31:0] w;
    base = blk_base(a);
    start_req(d, 1'b1, a);
    k = 0; p = 0; n = 0;
    while (k < BW && n < 200) begin
      v = use_pat ? (p < 7 ? pat[6-p] : 1'b1) : ($urandom_range(0, 3) != 0);
      chk("wdata_ready_beat", wdata_ready[d], 1);
      w = fixed ? d0 + 32'(k) : $urandom;
      wdata_valid[d] = v; wdata[d] = w;
      @(negedge clk);
      n++; p++;
      if (v) begin
        ref_mem[d][base+k] = w;
        known[d][base+k] = 1'b1;
        k++;
      end
    end
    wdata_valid[d] = 1'b0;
    if (use_pat) chk("gap_pattern_len", p, 7);
    chk("ack_valid", rsp_valid[d], 1);
    chk("ack_last", rsp_last[d], 1);
    chk("ack_data", rsp_data[d], 0);
    chk("ack_wdata_ready", wdata_ready[d], 0);
    for (int i = 0; i < $urandom_range(0, 2); i++) begin
      wdata_valid[d] = 1'b1; wdata[d] = $urandom;
      @(negedge clk);
      chk("ack_hold", rsp_valid[d] && rsp_last[d], 1);
    end
    wdata_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    exp_wr[d] = sat(exp_wr[d]);
    chk("wr_count", wr_count[d], exp_wr[d]);
    chk("rd_count_after_wr", rd_count[d], exp_rd[d]);
    chk("idle_after_wr", {busy[d], rsp_valid[d], req_ready[d]}, 3'b001);
  endtask

  // stall_beat: -2 no stalls, -1 random stalls, otherwise stall that beat stall_len cycles.
  task automatic rd_burst(input int d, input logic [31:0] a, input int stall_beat, input int stall_len);
    int base, s;
    base = blk_base(a);
    start_req(d, 1'b0, a);
    for (int k = 0; k < BW; k++) begin
      s = (k == stall_beat) ? stall_len : (stall_beat == -1 ? $urandom_range(0, 2) : 0);
      for (int i = 0; i < s; i++) begin
        rsp_ready[d] = 1'b0;
        chk("stall_valid", rsp_valid[d], 1);
        chk("stall_last", rsp_last[d], (k == BW - 1));
        if (known[d][base+k]) chk("stall_data", rsp_data[d], ref_mem[d][base+k]);
        @(negedge clk);
      end
      chk("rd_valid", rsp_valid[d], 1);
      chk("rd_last", rsp_last[d], (k == BW - 1));
      if (known[d][base+k]) chk("rd_data", rsp_data[d], ref_mem[d][base+k]);
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      rsp_ready[d] = 1'b0;
    end
    exp_rd[d] = sat(exp_rd[d]);
    chk("rd_count", rd_count[d], exp_rd[d]);
    chk("wr_count_after_rd", wr_count[d], exp_wr[d]);
    chk("idle_after_rd", {busy[d], rsp_valid[d], req_ready[d]}, 3'b001);
  endtask

  task automatic chk_reset_outputs(input int d);
    chk("rst_rsp_valid", rsp_valid[d], 0);
    chk("rst_rsp_last", rsp_last[d], 0);
    chk("rst_rsp_data", rsp_data[d], 0);
    chk("rst_wdata_ready", wdata_ready[d], 0);
    chk("rst_busy", busy[d], 0);
    chk("rst_rd_count", rd_count[d], 0);
    chk("rst_wr_count", wr_count[d], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    lat_of[0] = 4; lat_of[1] = 0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 32'd0;
      wdata_valid[d] = 1'b0; wdata[d] = 32'd0; rsp_ready[d] = 1'b0;
      exp_rd[d] = 0; exp_wr[d] = 0;
      for (int i = 0; i < MW; i++) known[d][i] = 1'b0;
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    reset = 1'b1;
    @(negedge clk);
    chk("req_ready_after_reset", req_ready[0], 1);

    // Write then read, first beat after LATENCY idle cycles.
    wr_burst(0, 32'h0000_0040, 1'b0, 7'd0, 1'b1, 32'h0000_00A0);
    rd_burst(0, 32'h0000_004C, -2, 0);
    chk("beat0_value", ref_mem[0][16], 32'h0000_00A0);

    // Backpressure: 3-cycle stall on the second beat.
    rd_burst(0, 32'h0000_0040, 1, 3);

    // Write-beat gaps; neighbouring block must stay intact.
    wr_burst(0, 32'h0000_0090, 1'b0, 7'd0, 1'b1, 32'h0000_00C0);
    wr_burst(0, 32'h0000_0080, 1'b1, 7'b1001101, 1'b1, 32'h0000_00B0);
    rd_burst(0, 32'h0000_0080, -2, 0);
    rd_burst(0, 32'h0000_0090, -2, 0);

    // Wrap-around: 0x1000 aliases 0x0000.
    wr_burst(0, 32'h0000_1000, 1'b0, 7'd0, 1'b1, 32'h0000_5A00);
    rd_burst(0, 32'h0000_0000, -1, 0);

    // Zero-latency instance.
    wr_burst(1, 32'h0000_0020, 1'b0, 7'd0, 1'b0, 32'd0);
    rd_burst(1, 32'h0000_0020, -2, 0);
    rd_burst(1, 32'h0000_0020, -1, 0);

    // Random traffic on both instances over a small set of blocks.
    for (int it = 0; it < 40; it++) begin
      for (int d = 0; d < 2; d++) begin
        a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 4) | ($urandom & 32'h0000_000F);
        if ($urandom_range(0, 1) == 1) wr_burst(d, a, 1'b0, 7'd0, 1'b0, 32'd0);
        else rd_burst(d, a, -1, 0);
      end
    end

    // Reset during a write after two of four beats.
    start_req(0, 1'b1, 32'h0000_0040);
    for (int k = 0; k < 2; k++) begin
      wdata_valid[0] = 1'b1; wdata[0] = 32'h0000_00D0 + 32'(k);
      @(negedge clk);
      ref_mem[0][16+k] = 32'h0000_00D0 + 32'(k);
      known[0][16+k] = 1'b1;
    end
    wdata_valid[0] = 1'b0;
    chk("midwrite_busy", busy[0], 1);
    reset = 1'b0;
    #1;
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    exp_rd[0] = 0; exp_wr[0] = 0; exp_rd[1] = 0; exp_wr[1] = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd_burst(0, 32'h0000_0040, -2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
